// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: request/response ports for masters A and B plus the SRAM pin bundle.
// Latency: none, wires only.
// Backpressure: none here; masters hold a level req until they see their ack.
interface sram_arbiter_if #(
  parameter int ADDR_W = 20
);
  // Port A (loader / write master)
  logic              i_a_req;
  logic              i_a_we;
  logic [ADDR_W-1:0] i_a_addr;
  logic [15:0]       i_a_wdata;
  logic [1:0]        i_a_be;
  logic              o_a_ack;
  logic [15:0]       o_a_rdata;
  // Port B (runtime master)
  logic              i_b_req;
  logic              i_b_we;
  logic [ADDR_W-1:0] i_b_addr;
  logic [15:0]       i_b_wdata;
  logic [1:0]        i_b_be;
  logic              o_b_ack;
  logic [15:0]       o_b_rdata;
  // SRAM pins
  logic [ADDR_W-1:0] o_sram_addr;
  logic [15:0]       o_sram_wdata;
  logic              o_sram_data_oe;
  logic [15:0]       i_sram_rdata;
  logic              o_sram_oe_n;
  logic              o_sram_we_n;
  logic              o_sram_ub_n;
  logic              o_sram_lb_n;
  logic              o_busy;

  // The arbiter side
  modport slave (
    input  i_a_req, i_a_we, i_a_addr, i_a_wdata, i_a_be,
    input  i_b_req, i_b_we, i_b_addr, i_b_wdata, i_b_be,
    input  i_sram_rdata,
    output o_a_ack, o_a_rdata, o_b_ack, o_b_rdata,
    output o_sram_addr, o_sram_wdata, o_sram_data_oe,
    output o_sram_oe_n, o_sram_we_n, o_sram_ub_n, o_sram_lb_n, o_busy
  );

  // The masters and the SRAM device side
  modport master (
    output i_a_req, i_a_we, i_a_addr, i_a_wdata, i_a_be,
    output i_b_req, i_b_we, i_b_addr, i_b_wdata, i_b_be,
    output i_sram_rdata,
    input  o_a_ack, o_a_rdata, o_b_ack, o_b_rdata,
    input  o_sram_addr, o_sram_wdata, o_sram_data_oe,
    input  o_sram_oe_n, o_sram_we_n, o_sram_ub_n, o_sram_lb_n, o_busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter + setup/strobe/hold sequencer owning the async 16-bit SRAM pins.
// Latency: ack in cycle WAIT_CYCLES+2 after req is sampled in IDLE; one access per WAIT_CYCLES+3 cycles.
// Backpressure: level req held until ack; tie loser waits. SRAM_ARB_RR_EN = round-robin ties, else A wins.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 20
) (
  input logic           i_clk,
  input logic           i_rst,
  sram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              gnt_b_q, gnt_b_d;    // 1 = port B owns the current access
  logic              cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic              oe_n_q, oe_n_d, we_n_q, we_n_d, ub_n_q, ub_n_d, lb_n_q, lb_n_d;
  logic              data_oe_q, data_oe_d, a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic              busy_q, busy_d;
  logic              pick_b;

`ifdef SRAM_ARB_RR_EN
  logic              last_b_q, last_b_d;  // 1 = B took the most recent grant
  // Round-robin: on a tie the port that did not win last time goes first
  assign pick_b = bus.i_b_req & (~bus.i_a_req | ~last_b_q);
`else
  // Fixed priority: A always wins a tie
  assign pick_b = bus.i_b_req & ~bus.i_a_req;
`endif

  // Next-state and registered-output logic for the access sequencer
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_b_d   = gnt_b_q;
    cmd_we_d  = cmd_we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    oe_n_d    = 1'b1;
    we_n_d    = 1'b1;
    ub_n_d    = ub_n_q;
    lb_n_d    = lb_n_q;
    data_oe_d = data_oe_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
`ifdef SRAM_ARB_RR_EN
    last_b_d  = last_b_q;
`endif
    case (state_q)
      IDLE: begin
        ub_n_d    = 1'b1;
        lb_n_d    = 1'b1;
        data_oe_d = 1'b0;
        if (bus.i_a_req || bus.i_b_req) begin
          state_d   = SETUP;
          gnt_b_d   = pick_b;
`ifdef SRAM_ARB_RR_EN
          last_b_d  = pick_b;
`endif
          cmd_we_d  = pick_b ? bus.i_b_we : bus.i_a_we;
          addr_d    = pick_b ? bus.i_b_addr : bus.i_a_addr;
          ub_n_d    = pick_b ? ~bus.i_b_be[1] : ~bus.i_a_be[1];
          lb_n_d    = pick_b ? ~bus.i_b_be[0] : ~bus.i_a_be[0];
          data_oe_d = cmd_we_d;
          if (cmd_we_d) wdata_d = pick_b ? bus.i_b_wdata : bus.i_a_wdata;
        end
      end
      SETUP: begin
        state_d = STROBE;
        cnt_d   = 4'(WAIT_CYCLES - 1);
        oe_n_d  = cmd_we_q;
        we_n_d  = ~cmd_we_q;
      end
      STROBE: begin
        if (cnt_q == 4'd0) begin
          // Last strobe cycle: release strobes, capture read data, ack in HOLD
          state_d = HOLD;
          a_ack_d = ~gnt_b_q;
          b_ack_d = gnt_b_q;
          if (!cmd_we_q) begin
            if (gnt_b_q) b_rdata_d = bus.i_sram_rdata;
            else         a_rdata_d = bus.i_sram_rdata;
          end
        end else begin
          cnt_d  = cnt_q - 4'd1;
          oe_n_d = oe_n_q;
          we_n_d = we_n_q;
        end
      end
      HOLD: begin
        // addr/be/data_oe were held through HOLD for write hold time; release now
        state_d   = IDLE;
        ub_n_d    = 1'b1;
        lb_n_d    = 1'b1;
        data_oe_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset parks the SRAM pins in their idle levels
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      gnt_b_q   <= 1'b1;
      cmd_we_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 16'h0000;
      a_rdata_q <= 16'h0000;
      b_rdata_q <= 16'h0000;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      ub_n_q    <= 1'b1;
      lb_n_q    <= 1'b1;
      data_oe_q <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      last_b_q  <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_b_q   <= gnt_b_d;
      cmd_we_q  <= cmd_we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      ub_n_q    <= ub_n_d;
      lb_n_q    <= lb_n_d;
      data_oe_q <= data_oe_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      busy_q    <= busy_d;
`ifdef SRAM_ARB_RR_EN
      last_b_q  <= last_b_d;
`endif
    end
  end

  assign bus.o_a_ack        = a_ack_q;
  assign bus.o_a_rdata      = a_rdata_q;
  assign bus.o_b_ack        = b_ack_q;
  assign bus.o_b_rdata      = b_rdata_q;
  assign bus.o_sram_addr    = addr_q;
  assign bus.o_sram_wdata   = wdata_q;
  assign bus.o_sram_data_oe = data_oe_q;
  assign bus.o_sram_oe_n    = oe_n_q;
  assign bus.o_sram_we_n    = we_n_q;
  assign bus.o_sram_ub_n    = ub_n_q;
  assign bus.o_sram_lb_n    = lb_n_q;
  assign bus.o_busy         = busy_q;

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-port arbiter and access sequencer for the board's 16-bit asynchronous SRAM (20-bit word address).
- Port A is the loader/write master, e.g. the CHR loader during init. Port B is the runtime master, e.g. PPU pattern fetch.
- The block owns all SRAM pins. It runs fixed-length setup/strobe/hold access cycles so that neither master drives the SRAM directly.
- Sits in device_mgr between the masters and the top-level SRAM pins.

Parameters:
- WAIT_CYCLES, 2, number of cycles the OE_n/WE_n strobe is held low (legal 1..15).
- ADDR_W, 20, SRAM word-address width.

Ports:
- i_clk  input  1  system clock
- i_rst  input  1  asynchronous reset, active-high
- i_a_req  input  1  port A request, level
- i_a_we  input  1  port A: 1=write, 0=read
- i_a_addr  input  ADDR_W  port A word address
- i_a_wdata  input  16  port A write data
- i_a_be  input  2  port A byte enables: [1]=upper byte, [0]=lower byte
- o_a_ack  output  1  port A completion pulse, 1 cycle
- o_a_rdata  output  16  port A read data
- i_b_req, i_b_we, i_b_addr, i_b_wdata, i_b_be, o_b_ack, o_b_rdata: same as port A, for port B
- o_sram_addr  output  ADDR_W  SRAM address
- o_sram_wdata  output  16  SRAM write data
- o_sram_data_oe  output  1  tristate enable for SRAM data pins
- i_sram_rdata  input  16  SRAM read data
- o_sram_oe_n, o_sram_we_n, o_sram_ub_n, o_sram_lb_n  output  1 each  SRAM strobes, active-low
- o_busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs are registered and reset asynchronously.
  - Strobes (oe_n, we_n, ub_n, lb_n) = 1.
  - data_oe = 0, acks = 0, busy = 0.
  - addr, wdata and both rdata outputs = 0.
  - FSM = IDLE; last_grant = B.
- FSM states: IDLE -> SETUP -> STROBE -> HOLD -> IDLE.
- IDLE:
  - If any req is high, pick a winner and latch its we/addr/wdata/be. Next state SETUP.
  - The latched command is immune to input changes until ack.
- SETUP (1 cycle):
  - addr driven; ub_n = ~be[1], lb_n = ~be[0].
  - oe_n and we_n stay high.
  - data_oe = 1 and wdata driven for writes only.
- STROBE (WAIT_CYCLES cycles, counted by a 4-bit down-counter):
  - Read: oe_n = 0. Write: we_n = 0.
  - On the clock edge ending the last STROBE cycle, reads capture i_sram_rdata into the granted port's rdata register.
- HOLD (1 cycle):
  - oe_n and we_n return to 1. addr, be and data_oe are held (write data hold time).
  - The granted port's ack = 1.
  - Next state IDLE: ub_n/lb_n go to 1, data_oe goes to 0, addr and wdata keep their last values.
- Latency: req sampled in IDLE at cycle 0 -> ack high in cycle WAIT_CYCLES+2. Throughput is one access per WAIT_CYCLES+3 cycles.
- Handshake:
  - A requester clears req at the edge where it samples ack=1.
  - A req still high in IDLE starts a new access; back-to-back accesses are legal.
- rdata:
  - Changes only on that port's read completion. Valid from its ack cycle and held until the next read by that port.
  - Writes leave rdata unchanged.
  - A read with be=00 still runs the full cycle with ub_n/lb_n high and captures whatever is on the bus.
- Arbitration: a tie is both reqs high in IDLE; a single req is always granted. Tie policy is set by the Optional Feature.
- Reset mid-operation: all strobes deassert in the same cycle, data_oe drops, the access is discarded with no ack, and the FSM returns to IDLE.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined: round-robin. On a tie, the port not in last_grant wins. last_grant is updated at every grant and resets to B, so A wins the first tie.
- Undefined: fixed priority. A always wins ties, B can starve, and the last_grant register is not generated.

Test Plan:
- Port A read, WAIT_CYCLES=2, addr=0x12345, SRAM model returns 0xBEEF -> oe_n low in cycles 2-3, o_a_ack high in cycle 4 only, o_a_rdata=0xBEEF, o_b_rdata unchanged.
- Port B write, addr=0x00010, wdata=0xA55A, be=2'b10 -> ub_n=0 and lb_n=1 in cycles 1-4, we_n low in cycles 2-3, data_oe high in cycles 1-4, o_b_ack in cycle 4, model upper byte=0xA5 with lower byte untouched.
- A and B both held high for 4 accesses -> with SRAM_RR_EN... correction: with SRAM_ARB_RR_EN the grant order is A,B,A,B; without it the order is A,A,A,A while B waits.
- Back-to-back A reads, req kept high for 2 accesses, WAIT_CYCLES=2 -> acks in cycles 4 and 9, with no strobe low during HOLD/IDLE.
- i_rst asserted during the second STROBE cycle of a write -> we_n=1 and data_oe=0 immediately, no ack, busy=0. After release, a new read completes normally.
- WAIT_CYCLES=1, single read -> oe_n low for exactly cycle 2, ack in cycle 3.
